instruction_encoder: RTL and testbench
======================================

Name: instruction_encoder

Overview:
- Converts a decoded instruction description (opcode, register fields, funct fields, 32-bit immediate) back into a 32-bit RV32 instruction word.
- It is the inverse of the core's immediate decoding. For every representable immediate, the immediate extracted from `out_inst` equals `in_imm`.
- Optionally expands the `li rd, imm` pseudo-instruction into one or two instructions (ADDI, or LUI then ADDI).
- Sits between a stimulus/patch source and any instruction sink: self-test ROM builder, trap-handler patcher, or bench driver. Valid/ready on both sides.

Parameters:
None.

Ports:
- clock  input  1  core clock; all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  request valid
- in_ready  output  1  block can accept a request this cycle
- in_expand  input  1  1 = encode `li in_rd, in_imm` (opcode, rs1, rs2, funct3, funct7 ignored)
- in_opcode  input  7  instruction opcode [6:0]
- in_rd  input  5  destination register
- in_rs1  input  5  source register 1
- in_rs2  input  5  source register 2
- in_funct3  input  3  funct3
- in_funct7  input  7  funct7 (R-layout only)
- in_imm  input  32  immediate as a decoded, sign-extended value
- out_valid  output  1  `out_inst` valid
- out_ready  input  1  sink accepts `out_inst` this cycle
- out_inst  output  32  encoded instruction
- out_error  output  1  `in_imm` not representable in the selected format; qualified by `out_valid`

Behaviour:

Reset:
- `out_valid`=0, `out_inst`=0, `out_error`=0, state=IDLE, pending register cleared.
- Reset has priority over every other event, including mid-expansion (pending second instruction dropped).

Handshakes:
- Input transfer when `in_valid && in_ready`.
- Output transfer when `out_valid && out_ready`.
- `in_ready` = (state==IDLE) && (!`out_valid` || `out_ready`). This is combinational from `out_ready`; no combinational path from `in_*` to `out_*`.
- Latency: an accepted request appears on `out_*` the next cycle.
- Outputs hold stable while `out_valid && !out_ready`.
- Full throughput of 1 instruction/cycle for non-expanding requests.

Format selection (`in_expand`=0):
- I (LOAD 0000011, LOAD_FP 0000111, OP_IMM 0010011, JALR 1100111): inst = {imm[11:0], rs1, funct3, rd, opcode}
- S (STORE 0100011, STORE_FP 0100111): inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
- B (BRANCH 1100011): inst = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
- U (LUI 0110111, AUIPC 0010111): inst = {imm[31:12], rd, opcode}
- J (JAL 1101111): inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
- Any other opcode → R layout: {funct7, rs2, rs1, funct3, rd, opcode}; immediate ignored; `out_error`=0.

Range checks (`out_error`=1 on failure; the word is still emitted with the truncated fields):
- I/S: imm[31:11] all equal.
- B: imm[0]==0 and imm[31:12] all equal.
- J: imm[0]==0 and imm[31:20] all equal.
- U: imm[11:0]==0.

Expansion (`in_expand`=1, `out_error` always 0):
- If imm[31:11] all equal → single ADDI rd,x0,imm (0x13 opcode, funct3 0).
- Else compute hi = (imm + 32'h800)[31:12] (mod 2^32, wrap allowed) and lo = imm[11:0].
  - First emit LUI rd,hi.
  - If lo≠0, a second instruction ADDI rd,rd,lo is latched as pending and state→SECOND.
  - If lo==0, LUI only.

FSM:
- IDLE → SECOND on accepting a two-instruction expansion.
- SECOND: `in_ready`=0. When the first output transfers, `out_inst`←pending, `out_valid` stays 1, state→IDLE.
- SECOND lasts ≥1 cycle and ends only on an output transfer.
- `rd`=x0 in expansion is encoded as given (no special case).

Test Plan:
- `in_expand`=1, rd=1, imm=5 → one output, `out_inst`=0x00500093, `out_error`=0, `in_ready` high next cycle.
- `in_expand`=1, rd=5, imm=0x12345FFF → 0x123462B7 then 0xFFF28293 on consecutive transfers; `in_ready`=0 while state=SECOND. Repeat with imm=0x00010000 → single 0x000102B7.
- BRANCH funct3=0, rs1=1, rs2=2, imm=0xFFFFFFFC → 0xFE208EE3, `out_error`=0. Same with imm=3 → `out_error`=1.
- JAL rd=1, imm=0x800 → 0x001000EF. LUI imm=0x00000123 → `out_error`=1. Randomised legal I/S/B/U/J requests round-tripped through the core's immediate decoder equal `in_imm`.
- Hold `out_ready`=0 for 5 cycles after an accepted request → `out_inst`/`out_error` stable, `in_ready`=0. Then `out_ready`=1 with back-to-back `in_valid` → one instruction per cycle, no loss or duplication.
- Assert `reset` while state=SECOND with `out_valid`=1 → next cycle `out_valid`=0, `in_ready`=1, pending ADDI never emitted.

Source files
------------

// File: rtl/instruction_encoder.sv
// Packs a decoded RV32 instruction description back into a 32-bit instruction word.
// It can also expand the li pseudo-instruction into ADDI, or into LUI followed by ADDI.
module instruction_encoder (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_expand,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic        out_error
);

  localparam logic [6:0] OpLoad    = 7'b0000011;
  localparam logic [6:0] OpLoadFp  = 7'b0000111;
  localparam logic [6:0] OpImm     = 7'b0010011;
  localparam logic [6:0] OpJalr    = 7'b1100111;
  localparam logic [6:0] OpStore   = 7'b0100011;
  localparam logic [6:0] OpStoreFp = 7'b0100111;
  localparam logic [6:0] OpBranch  = 7'b1100011;
  localparam logic [6:0] OpLui     = 7'b0110111;
  localparam logic [6:0] OpAuipc   = 7'b0010111;
  localparam logic [6:0] OpJal     = 7'b1101111;

  typedef enum logic [0:0] {StIdle, StSecond} state_e;

  state_e      state_q;
  logic        out_valid_q;
  logic [31:0] out_inst_q;
  logic        out_error_q;
  logic [31:0] pending_q;

  logic [31:0] enc_inst;
  logic        enc_error;
  logic        enc_two;
  logic [31:0] enc_second;
  logic        fits12;
  logic        fits13;
  logic        fits21;
  logic [19:0] hi20;

  assign in_ready  = (state_q == StIdle) && (!out_valid_q || out_ready);
  assign out_valid = out_valid_q;
  assign out_inst  = out_inst_q;
  assign out_error = out_error_q;

  assign fits12 = (&in_imm[31:11]) || !(|in_imm[31:11]);
  assign fits13 = (&in_imm[31:12]) || !(|in_imm[31:12]);
  assign fits21 = (&in_imm[31:20]) || !(|in_imm[31:20]);
  // Rounds the upper part so that the sign-extended ADDI low part restores the value.
  assign hi20   = in_imm[31:12] + {19'd0, in_imm[11]};

  always_comb begin
    enc_inst   = 32'd0;
    enc_error  = 1'b0;
    enc_two    = 1'b0;
    enc_second = {in_imm[11:0], in_rd, 3'b000, in_rd, OpImm};
    if (in_expand) begin
      if (fits12) begin
        enc_inst = {in_imm[11:0], 5'd0, 3'b000, in_rd, OpImm};
      end else begin
        enc_inst = {hi20, in_rd, OpLui};
        enc_two  = |in_imm[11:0];
      end
    end else begin
      case (in_opcode)
        OpLoad, OpLoadFp, OpImm, OpJalr: begin
          enc_inst  = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
          enc_error = !fits12;
        end
        OpStore, OpStoreFp: begin
          enc_inst  = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
          enc_error = !fits12;
        end
        OpBranch: begin
          enc_inst  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3, in_imm[4:1],
                       in_imm[11], in_opcode};
          enc_error = in_imm[0] || !fits13;
        end
        OpLui, OpAuipc: begin
          enc_inst  = {in_imm[31:12], in_rd, in_opcode};
          enc_error = |in_imm[11:0];
        end
        OpJal: begin
          enc_inst  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
          enc_error = in_imm[0] || !fits21;
        end
        default: begin
          enc_inst = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      out_inst_q  <= 32'd0;
      out_error_q <= 1'b0;
      pending_q   <= 32'd0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid && in_ready) begin
            out_valid_q <= 1'b1;
            out_inst_q  <= enc_inst;
            out_error_q <= enc_error;
            if (enc_two) begin
              pending_q <= enc_second;
              state_q   <= StSecond;
            end
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        StSecond: begin
          // The LUI is always valid here; swap in the ADDI once it has been taken.
          if (out_ready) begin
            out_inst_q  <= pending_q;
            out_error_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_encoder.sv
// Randomised and directed bench for instruction_encoder, scored against an arithmetic model
// and against the core-style immediate decoder.
module tb_instruction_encoder;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_expand;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_error;

  int checks = 0;
  int errors = 0;
  bit bp_run = 1'b0;

  typedef struct {
    logic [31:0] inst;
    logic        err;
    int          fmt;
    logic [31:0] imm;
  } exp_t;

  exp_t sb[$];

  instruction_encoder dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_expand (in_expand),
    .in_opcode (in_opcode),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_error (out_error)
  );

  always #5 clock = ~clock;

  // 0 = R / none, 1 = I, 2 = S, 3 = B, 4 = U, 5 = J
  function automatic int fmt_of(input logic [6:0] op);
    case (op)
      7'h03, 7'h07, 7'h13, 7'h67: return 1;
      7'h23, 7'h27:               return 2;
      7'h63:                      return 3;
      7'h37, 7'h17:               return 4;
      7'h6f:                      return 5;
      default:                    return 0;
    endcase
  endfunction

  function automatic logic [31:0] decode_imm(input int fmt, input logic [31:0] i);
    case (fmt)
      1:       return {{21{i[31]}}, i[30:20]};
      2:       return {{21{i[31]}}, i[30:25], i[11:7]};
      3:       return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
      4:       return {i[31:12], 12'd0};
      default: return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
    endcase
  endfunction

  task automatic push(input logic [31:0] inst, input logic err, input int fmt,
                      input logic [31:0] imm);
    exp_t e;
    e.inst = inst; e.err = err; e.fmt = fmt; e.imm = imm;
    sb.push_back(e);
  endtask

  // Reference: field placement by shifts, legality by signed numeric range.
  task automatic model_push();
    logic [31:0] imm, op, rd, rs1, rs2, f3, f7, w, hi, lo;
    int s;
    int fmt;
    logic err;
    imm = in_imm; s = $signed(in_imm);
    op = 32'(in_opcode); rd = 32'(in_rd); rs1 = 32'(in_rs1); rs2 = 32'(in_rs2);
    f3 = 32'(in_funct3); f7 = 32'(in_funct7);
    if (in_expand) begin
      if (s >= -2048 && s <= 2047) begin
        push(((imm & 32'hfff) << 20) | (rd << 7) | 32'h13, 1'b0, 0, imm);
      end else begin
        hi = (imm + 32'h800) >> 12;
        lo = imm & 32'hfff;
        push((hi << 12) | (rd << 7) | 32'h37, 1'b0, 0, imm);
        if (lo != 0) push((lo << 20) | (rd << 15) | (rd << 7) | 32'h13, 1'b0, 0, imm);
      end
    end else begin
      fmt = fmt_of(in_opcode);
      err = 1'b0;
      case (fmt)
        1: begin
          w = ((imm & 32'hfff) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
          err = !(s >= -2048 && s <= 2047);
        end
        2: begin
          w = (((imm >> 5) & 32'h7f) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
              | ((imm & 32'h1f) << 7) | op;
          err = !(s >= -2048 && s <= 2047);
        end
        3: begin
          w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3f) << 25) | (rs2 << 20)
              | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hf) << 8)
              | (((imm >> 11) & 1) << 7) | op;
          err = (imm % 2 != 0) || !(s >= -4096 && s <= 4095);
        end
        4: begin
          w = (imm & 32'hfffff000) | (rd << 7) | op;
          err = (imm & 32'hfff) != 0;
        end
        5: begin
          w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3ff) << 21)
              | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hff) << 12) | (rd << 7) | op;
          err = (imm % 2 != 0) || !(s >= -1048576 && s <= 1048575);
        end
        default: w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      endcase
      push(w, err, fmt, imm);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_extra: got inst %08h, expected no output", out_inst);
        end else begin
          e = sb.pop_front();
          if (out_inst !== e.inst || out_error !== e.err) begin
            errors++;
            $display("FAIL scoreboard: got inst %08h err %0b, expected inst %08h err %0b",
                     out_inst, out_error, e.inst, e.err);
          end
          if (e.fmt != 0 && !e.err) begin
            checks++;
            if (decode_imm(e.fmt, out_inst) !== e.imm) begin
              errors++;
              $display("FAIL round_trip: decoded %08h, expected %08h",
                       decode_imm(e.fmt, out_inst), e.imm);
            end
          end
        end
      end
      if (in_valid && in_ready) model_push();
    end
  end

  task automatic send(input logic ex, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm);
    int n;
    bit acc;
    in_expand = ex; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_valid = 1'b1;
    n = 0; acc = 1'b0;
    while (!acc && n < 100) begin
      @(negedge clock);
      acc = in_ready;
      n++;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready stayed %0b, expected 1", in_ready);
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((sb.size() != 0 || out_valid) && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    checks++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_drain: %0d outputs outstanding, out_valid %0b, expected 0 and 0",
               name, sb.size(), out_valid);
    end
  endtask

  task automatic expect_out(input string name, input logic [31:0] inst, input logic err,
                            input logic rdy);
    checks++;
    if (out_valid !== 1'b1 || out_inst !== inst || out_error !== err || in_ready !== rdy) begin
      errors++;
      $display("FAIL %s: got v%0b inst %08h err %0b rdy %0b, expected v1 inst %08h err %0b rdy %0b",
               name, out_valid, out_inst, out_error, in_ready, inst, err, rdy);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (out_valid !== 1'b0 || out_inst !== 32'd0 || out_error !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got v%0b inst %08h err %0b rdy %0b, expected v0 0 0 rdy1",
               out_valid, out_inst, out_error, in_ready);
    end
  endtask

  task automatic test_directed();
    out_ready = 1'b1;
    send(1, 7'h00, 5'd1, 0, 0, 0, 0, 32'd5);
    expect_out("li_small", 32'h00500093, 1'b0, 1'b1);
    send(1, 7'h00, 5'd5, 0, 0, 0, 0, 32'h12345fff);
    expect_out("li_lui", 32'h123462b7, 1'b0, 1'b0);
    @(posedge clock); #1;
    expect_out("li_addi", 32'hfff28293, 1'b0, 1'b1);
    send(1, 7'h00, 5'd5, 0, 0, 0, 0, 32'h00010000);
    expect_out("li_lui_only", 32'h000102b7, 1'b0, 1'b1);
    send(0, 7'h63, 0, 5'd1, 5'd2, 3'd0, 0, 32'hfffffffc);
    expect_out("branch_neg4", 32'hfe208ee3, 1'b0, 1'b1);
    send(0, 7'h63, 0, 5'd1, 5'd2, 3'd0, 0, 32'd3);
    expect_out("branch_odd", 32'hfe208ee3 & 32'h0000_0000 | 32'h00208163, 1'b1, 1'b1);
    send(0, 7'h6f, 5'd1, 0, 0, 0, 0, 32'h800);
    expect_out("jal_800", 32'h001000ef, 1'b0, 1'b1);
    send(0, 7'h37, 5'd1, 0, 0, 0, 0, 32'h123);
    expect_out("lui_low_bits", 32'h000000b7, 1'b1, 1'b1);
    drain("directed");
  endtask

  task automatic test_stall_back_to_back();
    time t0;
    out_ready = 1'b0;
    send(0, 7'h03, 5'd3, 5'd4, 0, 3'd2, 0, 32'hfffffff8);
    repeat (5) begin
      @(negedge clock);
      expect_out("stall_hold", 32'hff822183, 1'b0, 1'b0);
    end
    @(posedge clock); #1;
    out_ready = 1'b1;
    t0 = $time;
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) send(0, 7'h33, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom),
                           7'($urandom), $urandom);
      else send(0, 7'h13, 5'($urandom), 5'($urandom), 0, 3'($urandom), 0,
                {{20{1'b1}}, 12'($urandom)});
    end
    checks++;
    if ($time - t0 != 100) begin
      errors++;
      $display("FAIL back_to_back_rate: took %0t, expected 100", $time - t0);
    end
    drain("back_to_back");
  endtask

  task automatic test_random();
    logic [6:0] ops [10] = '{7'h03, 7'h07, 7'h13, 7'h67, 7'h23, 7'h27, 7'h63, 7'h37,
                             7'h17, 7'h6f};
    logic [31:0] r, imm;
    logic [6:0] op;
    int pick;
    bp_run = 1'b1;
    for (int i = 0; i < 300; i++) begin
      pick = $urandom_range(0, 11);
      r = $urandom;
      op = (pick < 10) ? ops[pick] : 7'h33;
      imm = r;
      if (pick < 10 && $urandom_range(0, 3) != 0) begin
        case (fmt_of(op))
          1, 2:    imm = {{20{r[11]}}, r[11:0]};
          3:       imm = {{19{r[12]}}, r[12:1], 1'b0};
          4:       imm = {r[31:12], 12'd0};
          default: imm = {{11{r[20]}}, r[20:1], 1'b0};
        endcase
      end else if (pick == 11 && r[0]) begin
        imm = {{20{r[11]}}, r[11:0]};
      end
      send(pick == 11, op, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom),
           7'($urandom), imm);
    end
    bp_run = 1'b0;
    @(posedge clock); #1;
    drain("random");
  endtask

  task automatic test_reset_mid_expand();
    out_ready = 1'b0;
    send(1, 7'h00, 5'd5, 0, 0, 0, 0, 32'h12345fff);
    expect_out("second_pre_reset", 32'h123462b7, 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_inst !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid: got v%0b rdy %0b inst %08h, expected v0 rdy1 inst 0",
               out_valid, in_ready, out_inst);
    end
    out_ready = 1'b1;
    repeat (5) begin
      @(negedge clock);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL pending_dropped: got out_valid %0b inst %08h, expected 0",
                 out_valid, out_inst);
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clock); #1;
      if (bp_run) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_expand = 1'b0; in_opcode = '0; in_rd = '0;
    in_rs1 = '0; in_rs2 = '0; in_funct3 = '0; in_funct7 = '0; in_imm = '0; out_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    test_reset();
    @(posedge clock); #1;
    test_directed();
    test_stall_back_to_back();
    test_random();
    test_reset_mid_expand();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
